// File: rtl/control_fsm_if.sv
// Decoder inputs, datapath controls and req/rdy memory handshake for control_fsm.
// master = control unit, slave = decoder/datapath/memory side.
`timescale 1ns/1ps
interface control_fsm_if #(
  parameter int ID_W  = 5,
  parameter int ALU_W = 4
);
  logic [ID_W-1:0]  instr_id;
  logic [ALU_W-1:0] alu_ctrl_in;
  logic             mem_rdy;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             instr_load;
  logic [ALU_W-1:0] alu_ctrl;
  logic             alu_src_imm;
  logic             rf_we;
  logic [1:0]       rf_wsel;
  logic             pc_we;
  logic             pc_sel;
  logic             illegal;
  logic             retired;

  modport master (
    input  instr_id, alu_ctrl_in, mem_rdy,
    output mem_req, mem_we, mem_addr_sel, instr_load, alu_ctrl, alu_src_imm,
           rf_we, rf_wsel, pc_we, pc_sel, illegal, retired
  );

  modport slave (
    output instr_id, alu_ctrl_in, mem_rdy,
    input  mem_req, mem_we, mem_addr_sel, instr_load, alu_ctrl, alu_src_imm,
           rf_we, rf_wsel, pc_we, pc_sel, illegal, retired
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle RV32I-subset control unit: FETCH/DECODE/EXEC/MEM/WB with req/rdy memory handshake.
// Optional CTRL_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
`timescale 1ns/1ps
module control_fsm #(
  parameter int ID_W  = 5,
  parameter int ALU_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.master bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]   cycle_cnt,
  output logic [31:0]   retire_cnt
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [ID_W-1:0] ID_ALU_HI = ID_W'(16);
  localparam logic [ID_W-1:0] ID_I_LO   = ID_W'(10);
  localparam logic [ID_W-1:0] ID_LW     = ID_W'(17);
  localparam logic [ID_W-1:0] ID_SW     = ID_W'(18);
  localparam logic [ID_W-1:0] ID_JAL    = ID_W'(19);

  state_t           state;
  logic [ID_W-1:0]  id_q;
  logic [ALU_W-1:0] alu_ctrl_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic             mem_addr_sel_q;
  logic             alu_src_imm_q;
  logic             rf_we_q;
  logic [1:0]       rf_wsel_q;
  logic             pc_we_q;
  logic             pc_sel_q;
  logic             illegal_q;
  logic             retired_q;
  logic             sw_done;
  logic             retired;

  function automatic logic is_alu(input logic [ID_W-1:0] id);
    return (id != '0) && (id <= ID_ALU_HI);
  endfunction

  function automatic logic is_mem(input logic [ID_W-1:0] id);
    return (id == ID_LW) || (id == ID_SW);
  endfunction

  // Outputs are registered for the state being entered, so each branch loads
  // the control word of the next state rather than the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      id_q           <= '0;
      alu_ctrl_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      alu_src_imm_q  <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_wsel_q      <= '0;
      pc_we_q        <= 1'b0;
      pc_sel_q       <= 1'b0;
      illegal_q      <= 1'b0;
      retired_q      <= 1'b0;
    end else begin
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      alu_src_imm_q  <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_wsel_q      <= '0;
      pc_we_q        <= 1'b0;
      pc_sel_q       <= 1'b0;
      illegal_q      <= 1'b0;
      retired_q      <= 1'b0;
      case (state)
        FETCH: begin
          // mem_req_q is low only in the first cycle after reset; rdy is not a grant then.
          if (mem_req_q && bus.mem_rdy) state <= DECODE;
          else mem_req_q <= 1'b1;
        end
        DECODE: begin
          state      <= EXEC;
          id_q       <= bus.instr_id;
          alu_ctrl_q <= is_mem(bus.instr_id) ? '0 : bus.alu_ctrl_in;
          if (is_alu(bus.instr_id)) begin
            alu_src_imm_q <= (bus.instr_id >= ID_I_LO);
            rf_we_q       <= 1'b1;
            pc_we_q       <= 1'b1;
            retired_q     <= 1'b1;
          end else if (is_mem(bus.instr_id)) begin
            alu_src_imm_q <= 1'b1;
          end else if (bus.instr_id == ID_JAL) begin
            rf_we_q   <= 1'b1;
            rf_wsel_q <= 2'd2;
            pc_we_q   <= 1'b1;
            pc_sel_q  <= 1'b1;
            retired_q <= 1'b1;
          end else begin
            illegal_q <= 1'b1;
            pc_we_q   <= 1'b1;
          end
        end
        EXEC: begin
          mem_req_q <= 1'b1;
          if (is_mem(id_q)) begin
            state          <= MEM;
            mem_addr_sel_q <= 1'b1;
            alu_src_imm_q  <= 1'b1;
            mem_we_q       <= (id_q == ID_SW);
          end else begin
            state <= FETCH;
          end
        end
        MEM: begin
          if (bus.mem_rdy) begin
            if (id_q == ID_SW) begin
              state     <= FETCH;
              mem_req_q <= 1'b1;
            end else begin
              state     <= WB;
              rf_we_q   <= 1'b1;
              rf_wsel_q <= 2'd1;
              pc_we_q   <= 1'b1;
              retired_q <= 1'b1;
            end
          end else begin
            mem_req_q      <= 1'b1;
            mem_addr_sel_q <= 1'b1;
            alu_src_imm_q  <= 1'b1;
            mem_we_q       <= mem_we_q;
          end
        end
        WB: begin
          state     <= FETCH;
          mem_req_q <= 1'b1;
        end
        default: begin
          state     <= FETCH;
          mem_req_q <= 1'b1;
        end
      endcase
    end
  end

  // SW retires in the MEM cycle that receives rdy, so that completion cannot be registered.
  assign sw_done = (state == MEM) && bus.mem_rdy && (id_q == ID_SW);
  assign retired = retired_q | sw_done;

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr_sel = mem_addr_sel_q;
  assign bus.instr_load   = (state == FETCH) && mem_req_q && bus.mem_rdy;
  assign bus.alu_ctrl     = alu_ctrl_q;
  assign bus.alu_src_imm  = alu_src_imm_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_wsel      = rf_wsel_q;
  assign bus.pc_we        = pc_we_q | sw_done;
  assign bus.pc_sel       = pc_sel_q;
  assign bus.illegal      = illegal_q;
  assign bus.retired      = retired;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retired) retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: a driver issues randomized instructions and memory
// wait patterns, pushing expected completions; a monitor pops and checks each completion.
`timescale 1ns/1ps
module tb_control_fsm;
  localparam int ID_W  = 5;
  localparam int ALU_W = 4;
  localparam int N     = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;

  control_fsm_if #(.ID_W(ID_W), .ALU_W(ALU_W)) bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
`endif

  control_fsm #(.ID_W(ID_W), .ALU_W(ALU_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int rf_we;
    int wsel;
    int pc_sel;
    int illegal;
    int retired;
    int src_imm;
    int alu;
    int memcyc;
    int wecyc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  int unsigned ids [N];
  int unsigned alus[N];
  int unsigned fws [N];
  int unsigned mws [N];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.instr_load, bus.alu_ctrl,
                 bus.alu_src_imm, bus.rf_we, bus.rf_wsel, bus.pc_we, bus.pc_sel,
                 bus.illegal, bus.retired});
  endfunction

  // Reference: instruction class decides the completion controls; latency counts
  // fetch waits + fetch + decode + exec, plus memory waits + access (+ writeback for LW).
  function automatic exp_t model(input int unsigned id, input int unsigned alu,
                                 input int unsigned fw, input int unsigned mw);
    exp_t e;
    e.lat = int'(fw) + 3; e.rf_we = 0; e.wsel = 0; e.pc_sel = 0; e.illegal = 0;
    e.retired = 1; e.src_imm = 0; e.alu = int'(alu); e.memcyc = 0; e.wecyc = 0;
    if (id >= 1 && id <= 9) begin
      e.rf_we = 1;
    end else if (id >= 10 && id <= 16) begin
      e.rf_we = 1; e.src_imm = 1;
    end else if (id == 17) begin
      e.lat = int'(fw + mw) + 5; e.rf_we = 1; e.wsel = 1; e.alu = 0; e.memcyc = int'(mw) + 1;
    end else if (id == 18) begin
      e.lat = int'(fw + mw) + 4; e.src_imm = 1; e.alu = 0;
      e.memcyc = int'(mw) + 1; e.wecyc = int'(mw) + 1;
    end else if (id == 19) begin
      e.rf_we = 1; e.wsel = 2; e.pc_sel = 1;
    end else begin
      e.illegal = 1; e.retired = 0;
    end
    return e;
  endfunction

`ifdef CTRL_PERF_CNT_EN
  int unsigned edges_model;
  always @(posedge clk or posedge rst)
    if (rst) edges_model <= 0;
    else     edges_model <= edges_model + 1;
`endif

  initial begin : monitor
    int cyc, memc, wec, rfc, ldc, illc, retc, rets;
    bit started;
    exp_t e;
    cyc = 0; memc = 0; wec = 0; rfc = 0; ldc = 0; illc = 0; retc = 0; rets = 0; started = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        cyc = 0; memc = 0; wec = 0; rfc = 0; ldc = 0; illc = 0; retc = 0; rets = 0; started = 0;
        continue;
      end
      if (!started && !bus.mem_req) continue;
      started = 1;
      cyc++;
      if (bus.mem_req && bus.mem_addr_sel) memc++;
      if (bus.mem_we)     wec++;
      if (bus.rf_we)      rfc++;
      if (bus.instr_load) ldc++;
      if (bus.illegal)    illc++;
      if (bus.retired)    retc++;
      if (bus.pc_we) begin
        if (exp_q.size() == 0) begin
          check("spurious completion", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("latency",     cyc, e.lat);
          check("rf_we",       int'(bus.rf_we), e.rf_we);
          check("rf_wsel",     int'(bus.rf_wsel), e.wsel);
          check("pc_sel",      int'(bus.pc_sel), e.pc_sel);
          check("illegal",     illc, e.illegal);
          check("retired",     retc, e.retired);
          check("alu_src_imm", int'(bus.alu_src_imm), e.src_imm);
          check("alu_ctrl",    int'(bus.alu_ctrl), e.alu);
          check("mem cycles",  memc, e.memcyc);
          check("mem_we cycles", wec, e.wecyc);
          check("rf_we count", rfc, e.rf_we);
          check("instr_load count", ldc, 1);
`ifdef CTRL_PERF_CNT_EN
          check("cycle_cnt",  int'(cycle_cnt), int'(edges_model));
          check("retire_cnt", int'(retire_cnt), rets);
`endif
          rets += e.retired;
        end
        cyc = 0; memc = 0; wec = 0; rfc = 0; ldc = 0; illc = 0; retc = 0;
      end
    end
  end

  initial begin : driver
    int unsigned k, fw, mw, cur;
    bit dec_next, first, finished;

    ids[0] = 1;  alus[0] = 0;  fws[0] = 0; mws[0] = 0;
    ids[1] = 17; alus[1] = 7;  fws[1] = 0; mws[1] = 3;
    ids[2] = 18; alus[2] = 5;  fws[2] = 0; mws[2] = 0;
    ids[3] = 19; alus[3] = 2;  fws[3] = 1; mws[3] = 0;
    ids[4] = 0;  alus[4] = 9;  fws[4] = 0; mws[4] = 0;
    ids[5] = 31; alus[5] = 1;  fws[5] = 2; mws[5] = 0;
    ids[6] = 16; alus[6] = 15; fws[6] = 0; mws[6] = 0;
    for (int i = 7; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       ids[i] = $urandom_range(0, 31);
        1:       ids[i] = 17 + $urandom_range(0, 1);
        2:       ids[i] = $urandom_range(1, 16);
        default: ids[i] = ($urandom_range(0, 1) != 0) ? 19 : 0;
      endcase
      alus[i] = $urandom_range(0, 15);
      fws[i]  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      mws[i]  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
    end

    // Reset state, then an LW aborted by reset while its memory access is stalled.
    bus.instr_id = '0; bus.alu_ctrl_in = '0; bus.mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("outputs in reset", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("first mem_req", int'(bus.mem_req), 1);
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    bus.instr_id = ID_W'(17); bus.alu_ctrl_in = ALU_W'(3); bus.mem_rdy = 1'b0;
    @(negedge clk);
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    check("LW mem request", int'({bus.mem_req, bus.mem_addr_sel, bus.mem_we}), 6);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    check("LW req held", int'({bus.mem_req, bus.mem_addr_sel}), 3);
    #3 rst = 1'b1;
    #1 check("async clear mid-MEM", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    k = 0; fw = fws[0]; mw = 0; cur = 0;
    dec_next = 0; first = 1; finished = 0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      @(negedge clk);
      if (first) begin
        check("mem_req after abort", int'(bus.mem_req), 1);
        check("rf_we after abort", int'(bus.rf_we), 0);
        first = 0;
      end
      if (dec_next) begin
        bus.instr_id    = ID_W'(ids[cur]);
        bus.alu_ctrl_in = ALU_W'(alus[cur]);
        exp_q.push_back(model(ids[cur], alus[cur], fws[cur], mws[cur]));
        mw = mws[cur];
        dec_next = 0;
      end else begin
        bus.instr_id    = ID_W'($urandom);
        bus.alu_ctrl_in = ALU_W'($urandom);
      end
      if (bus.mem_req && !bus.mem_addr_sel) begin
        if (k == N) begin
          bus.mem_rdy = 1'b0;
        end else if (fw == 0) begin
          bus.mem_rdy = 1'b1;
          cur = k; k++; dec_next = 1;
          if (k < N) fw = fws[k];
        end else begin
          bus.mem_rdy = 1'b0; fw--;
        end
      end else if (bus.mem_req) begin
        bus.mem_rdy = (mw == 0);
        if (mw > 0) mw--;
      end else begin
        bus.mem_rdy = 1'($urandom);
      end
      if (k == N && !dec_next && exp_q.size() == 0) finished = 1;
    end
    check("run completes", int'(finished), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
